// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE operand loader and its watchdog.
package pe_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int CMD_WIDTH_DEF  = 2;

   typedef enum logic [1:0] {
      NO_CMD    = 2'b00,
      WRITE_CMD = 2'b01,
      START_CMD = 2'b10
   } pe_cmd_t;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_PAD,
      ST_START,
      ST_WAIT
   } loader_state_t;

endpackage

// File: rtl/pe_watchdog.sv
// WAIT-state watchdog: counts enabled cycles and flags expiry on the
// cycle the count sits at TIMEOUT-1.
module pe_watchdog #(
   parameter int TIMEOUT = 1024,
   localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire = enable & (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable & ~expire) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pe_operand_loader.sv
// Converts a valid/ready operand stream into PE command-word writes:
// DATA_NUM WRITE frames (zero-padded for short batches), then one START.
//
// state    | meaning
// ST_LOAD  | accepting operand words, one WRITE frame per handshake
// ST_PAD   | filling the rest of the buffer with zero-data WRITE frames
// ST_START | issuing the START frame at address 0
// ST_WAIT  | waiting for pe_done or watchdog expiry
module pe_operand_loader
   import pe_pkg::*;
#(
   parameter int DATA_NUM   = 16,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
   parameter int TIMEOUT    = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic                              in_last,
   output logic                              pe_wen,
   output logic [CMD_WIDTH+DATA_WIDTH-1:0]   pe_wdata,
   output logic [$clog2(DATA_NUM)-1:0]       pe_addr,
   input  logic                              pe_done,
   output logic                              busy,
   output logic                              timeout_err,
   output logic [15:0]                       batch_cnt
);

   localparam int            AW        = $clog2(DATA_NUM);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_NUM - 1);
   localparam logic [CMD_WIDTH-1:0] CMD_WR = CMD_WIDTH'(WRITE_CMD);
   localparam logic [CMD_WIDTH-1:0] CMD_ST = CMD_WIDTH'(START_CMD);

   loader_state_t                        state_q;
   logic [AW-1:0]                        wr_ptr_q;
   logic                                 pe_wen_q;
   logic [CMD_WIDTH+DATA_WIDTH-1:0]      pe_wdata_q;
   logic [AW-1:0]                        pe_addr_q;
   logic                                 timeout_err_q;
   logic [15:0]                          batch_cnt_q;
   logic                                 wd_expire;

   pe_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_q == ST_START),
      .enable (state_q == ST_WAIT),
      .expire (wd_expire)
   );

   // in_ready is combinational so it drops the instant reset is asserted.
   assign in_ready    = (state_q == ST_LOAD) & ~rst;
   assign busy        = (state_q != ST_LOAD);
   assign pe_wen      = pe_wen_q;
   assign pe_wdata    = pe_wdata_q;
   assign pe_addr     = pe_addr_q;
   assign timeout_err = timeout_err_q;
   assign batch_cnt   = batch_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_LOAD;
         wr_ptr_q      <= '0;
         pe_wen_q      <= 1'b0;
         pe_wdata_q    <= '0;
         pe_addr_q     <= '0;
         timeout_err_q <= 1'b0;
         batch_cnt_q   <= '0;
      end else begin
         pe_wen_q   <= 1'b0;
         pe_wdata_q <= '0;
         pe_addr_q  <= '0;
         case (state_q)
            ST_LOAD: begin
               if (in_valid & in_ready) begin
                  pe_wen_q   <= 1'b1;
                  pe_wdata_q <= {CMD_WR, in_data};
                  pe_addr_q  <= wr_ptr_q;
                  wr_ptr_q   <= wr_ptr_q + AW'(1);
                  if (wr_ptr_q == LAST_ADDR) begin
                     state_q <= ST_START;
                  end else if (in_last) begin
                     state_q <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               pe_wen_q   <= 1'b1;
               pe_wdata_q <= {CMD_WR, {DATA_WIDTH{1'b0}}};
               pe_addr_q  <= wr_ptr_q;
               wr_ptr_q   <= wr_ptr_q + AW'(1);
               if (wr_ptr_q == LAST_ADDR) begin
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               pe_wen_q   <= 1'b1;
               pe_wdata_q <= {CMD_ST, {DATA_WIDTH{1'b0}}};
               pe_addr_q  <= '0;
               wr_ptr_q   <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               // A completion landing on the expiry cycle still counts as success.
               if (pe_done) begin
                  batch_cnt_q <= batch_cnt_q + 16'd1;
                  state_q     <= ST_LOAD;
               end else if (wd_expire) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= ST_LOAD;
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_operand_loader.sv
// Directed bench for pe_operand_loader (DATA_NUM=16, TIMEOUT=8).
module tb_pe_operand_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0;
   logic        in_last = 1'b0;
   logic        pe_wen;
   logic [17:0] pe_wdata;
   logic [3:0]  pe_addr;
   logic        pe_done = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic [15:0] batch_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [21:0] frames[$];
   logic [15:0] exp_words[$];

   pe_operand_loader #(
      .DATA_NUM(16), .DATA_WIDTH(16), .CMD_WIDTH(2), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .pe_wen(pe_wen),
      .pe_wdata(pe_wdata), .pe_addr(pe_addr), .pe_done(pe_done),
      .busy(busy), .timeout_err(timeout_err), .batch_cnt(batch_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pe_wen) frames.push_back({pe_addr, pe_wdata});
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      exp_words.push_back(d);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Leaves the caller in the cycle right after the START frame edge (WAIT cycle 0).
   task automatic wait_start();
      int c;
      c = 0;
      while (c < 60 && !(pe_wen && pe_wdata[17:16] == 2'b10)) begin
         tick();
         c++;
      end
      chk("start_seen", {31'd0, pe_wen && pe_wdata[17:16] == 2'b10}, 32'd1);
   endtask

   // k operand words, then zero pads, then START at address 0.
   task automatic check_frames(input string tag, input int k);
      logic [21:0] obs;
      logic [21:0] exp;
      chk({tag, "_nframes"}, frames.size(), 32'd17);
      for (int i = 0; i < 17; i++) begin
         obs = (i < frames.size()) ? frames[i] : 22'h3FFFFF;
         if (i == 16) exp = {4'h0, 2'b10, 16'h0000};
         else         exp = {4'(i), 2'b01, (i < k) ? exp_words[i] : 16'h0000};
         chk($sformatf("%s_frame%0d", tag, i), {10'd0, obs}, {10'd0, exp});
      end
   endtask

   task automatic new_batch();
      frames.delete();
      exp_words.delete();
   endtask

   initial begin
      int idx;
      int starts;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_pe_wen", {31'd0, pe_wen}, 32'd0);
      chk("rst_pe_wdata", {14'd0, pe_wdata}, 32'd0);
      chk("rst_pe_addr", {28'd0, pe_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_batch_cnt", {16'd0, batch_cnt}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Full batch, back to back
      new_batch();
      for (int i = 1; i <= 16; i++) send_word(16'(i * 16'h0101), 1'b0);
      chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("full_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("full_start_wdata", {14'd0, pe_wdata}, 32'h0002_0000);
      chk("full_start_addr", {28'd0, pe_addr}, 32'd0);
      repeat (4) tick();
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("full_batch_cnt", {16'd0, batch_cnt}, 32'd1);
      chk("full_in_ready_back", {31'd0, in_ready}, 32'd1);
      chk("full_busy_low", {31'd0, busy}, 32'd0);
      chk("full_idle_wdata", {14'd0, pe_wdata}, 32'd0);
      repeat (2) tick();
      check_frames("full", 16);

      // Spurious done and bare in_last during LOAD
      pe_done = 1'b1;
      in_last = 1'b1;
      tick();
      pe_done = 1'b0;
      in_last = 1'b0;
      tick();
      chk("spurious_batch_cnt", {16'd0, batch_cnt}, 32'd1);
      chk("spurious_busy", {31'd0, busy}, 32'd0);
      chk("spurious_no_wen", {31'd0, pe_wen}, 32'd0);

      // Short batch of 3
      new_batch();
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      send_word(16'h3333, 1'b1);
      for (int c = 0; c < 60 && frames.size() < 17; c++) tick();
      repeat (3) tick();
      check_frames("short", 3);
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("short_batch_cnt", {16'd0, batch_cnt}, 32'd2);

      // Backpressure, then done and expiry on the same cycle
      new_batch();
      idx = 0;
      for (int c = 0; c < 400 && idx < 16; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 16'h5000 + 16'(idx);
         tick();
         if (in_valid) begin
            exp_words.push_back(16'h5000 + 16'(idx));
            idx++;
         end
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", idx, 32'd16);
      wait_start();
      repeat (7) tick();
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("simul_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("simul_batch_cnt", {16'd0, batch_cnt}, 32'd3);
      chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
      check_frames("bp", 16);

      // Watchdog expiry
      new_batch();
      for (int i = 0; i < 16; i++) send_word(16'h0F00 + 16'(i), 1'b0);
      wait_start();
      repeat (7) tick();
      chk("wd_err_before", {31'd0, timeout_err}, 32'd0);
      chk("wd_busy_before", {31'd0, busy}, 32'd1);
      tick();
      chk("wd_err_after", {31'd0, timeout_err}, 32'd1);
      chk("wd_busy_after", {31'd0, busy}, 32'd0);
      chk("wd_batch_cnt", {16'd0, batch_cnt}, 32'd3);
      check_frames("wd", 16);

      // Next batch after an abort
      new_batch();
      for (int i = 0; i < 16; i++) send_word(16'h7700 + 16'(i), 1'b0);
      wait_start();
      repeat (2) tick();
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("after_wd_batch_cnt", {16'd0, batch_cnt}, 32'd4);
      chk("after_wd_err_sticky", {31'd0, timeout_err}, 32'd1);
      check_frames("after_wd", 16);

      // Reset mid-batch
      new_batch();
      for (int i = 0; i < 7; i++) send_word(16'hE000 + 16'(i), 1'b0);
      chk("mid_wen_before", {31'd0, pe_wen}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wen", {31'd0, pe_wen}, 32'd0);
      chk("mid_rst_wdata", {14'd0, pe_wdata}, 32'd0);
      chk("mid_rst_addr", {28'd0, pe_addr}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_err", {31'd0, timeout_err}, 32'd0);
      chk("mid_rst_batch_cnt", {16'd0, batch_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (20) tick();
      starts = 0;
      foreach (frames[i]) if (frames[i][17:16] == 2'b10) starts++;
      chk("mid_no_start", starts, 32'd0);

      new_batch();
      send_word(16'hABCD, 1'b1);
      chk("restart_addr", {28'd0, pe_addr}, 32'd0);
      chk("restart_wdata", {14'd0, pe_wdata}, 32'h0001_ABCD);
      for (int c = 0; c < 60 && frames.size() < 17; c++) tick();
      check_frames("restart", 1);
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("restart_batch_cnt", {16'd0, batch_cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
